sum_uart_tx: RTL and testbench

//   Downstream stage of latch_2x8. Snapshots the two latched 4-bit operands, adds them, and sends
//   the sum over a UART TX line as a 4-byte ASCII frame: tens digit, ones digit, CR (0x0D),
//   LF (0x0A). Format is 8N1, LSB first. Rising edge on start launches one frame.

---
 rtl/sum_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_sum_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_uart_tx.sv
// -----------------------------------------------------------------------------
// sum_uart_tx
//
// Purpose
//   Takes a snapshot of two 4-bit operands when a frame is requested, adds
//   them, and sends the decimal sum over a UART TX line. Each frame holds
//   four bytes: the ASCII tens digit, the ASCII ones digit, CR (0x0D) and
//   LF (0x0A). The line format is 8N1, LSB first. A leading zero is always
//   sent, so a sum of 5 goes out as "05".
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (must be >= 2)
//
// Ports
//   clk      in   1  system clock, the only clock domain
//   reset    in   1  synchronous, active-high reset
//   start    in   1  level input; each rising edge requests one frame
//   q_a      in   4  operand A, unsigned
//   q_b      in   4  operand B, unsigned
//   tx       out  1  UART serial output, idles high
//   busy     out  1  high while a frame is in progress
//   done     out  1  one-cycle pulse on the first idle cycle after a frame
//   sum_out  out  5  sum captured when the frame was accepted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] q_a,
    input  logic [3:0] q_b,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [4:0] sum_out
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [1:0]    byte_idx;
    logic [1:0]    byte_next;
    logic          start_q;
    logic          req;
    logic          baud_last;
    logic          tx_next;
    logic          busy_next;
    logic          done_next;
    logic [4:0]    sum_next;
    logic [1:0]    tens;
    logic [3:0]    ones;
    logic [7:0]    cur_byte;

    // Only a 0->1 transition of start counts as a request. A start held
    // high therefore launches a single frame.
    assign req       = start & ~start_q;
    assign baud_last = (baud_cnt == BAUD_LAST);

    // The sum never exceeds 30, so the tens digit is found with three
    // compares instead of a divider. The remainder always fits in 4 bits.
    always_comb begin
        tens = 2'd0;
        ones = sum_out[3:0];
        if (sum_out >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(sum_out - 5'd30);
        end else if (sum_out >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(sum_out - 5'd20);
        end else if (sum_out >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(sum_out - 5'd10);
        end
    end

    // The byte to send is selected by the byte index of the coming cycle.
    // tx is registered, so its value must match the state that is about to
    // be entered. Both digits are below 10, so ORing them into 0x30 gives
    // their ASCII codes.
    always_comb begin
        case (byte_next)
            2'd0:    cur_byte = {4'h3, 2'b00, tens};
            2'd1:    cur_byte = {4'h3, ones};
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Next-state logic. The baud counter restarts at 0 on every bit
    // boundary, so each bit lasts exactly CLKS_PER_BIT cycles. After the
    // last stop bit the FSM returns to IDLE and raises done. Because done
    // is registered, it goes high in the same cycle that the FSM is back in
    // IDLE. A new request in that cycle is accepted.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        done_next  = 1'b0;
        sum_next   = sum_out;

        case (state)
            IDLE: begin
                if (req) begin
                    state_next = START;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    byte_next  = 2'd0;
                    sum_next   = {1'b0, q_a} + {1'b0, q_b};
                end
            end
            START: begin
                if (baud_last) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (byte_idx != 2'd3) begin
                        byte_next  = byte_idx + 2'd1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_byte[bit_next];
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers. Reset has priority, so a request in the
    // same cycle as reset is dropped. A reset in the middle of a frame ends
    // the frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            start_q  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= 5'd0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            start_q  <= start;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
            sum_out  <= sum_next;
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_sum_uart_tx
//
// Purpose
//   Self-checking bench for sum_uart_tx with CLKS_PER_BIT = 4, so one frame
//   lasts 160 cycles. Expected ASCII bytes are pushed to a queue when a frame
//   is launched. A serial decoder samples each bit at its midpoint and
//   compares every received byte with the next entry popped from the queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sum_uart_tx;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] q_a;
    logic [3:0] q_b;
    logic       tx;
    logic       busy;
    logic       done;
    logic [4:0] sum_out;

    int         vectors;
    int         miscompares;
    int         cycle;
    int         busy_rises;
    logic       busy_prev;
    logic [7:0] exp_q[$];

    sum_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .q_a     (q_a),
        .q_b     (q_b),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, plus a count of frames started (rising edges of busy).
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises <= busy_rises + 1;
        busy_prev <= busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the four bytes a frame carrying a+b should contain.
    task automatic push_expected(input logic [3:0] a, input logic [3:0] b);
        int s;
        s = int'(a) + int'(b);
        exp_q.push_back(8'(8'h30 + s / 10));
        exp_q.push_back(8'(8'h30 + s % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Raise start at a negedge and check the outputs one cycle after
    // acceptance. Start stays high if hold is set.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit hold);
        @(negedge clk);
        q_a   = a;
        q_b   = b;
        start = 1'b1;
        push_expected(a, b);
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("accept_sum", 32'(sum_out), 32'(int'(a) + int'(b)));
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_tx", 32'(tx), 32'd0);
    endtask

    // Decode four bytes from tx and compare them with the queue. Then check
    // the frame length (done exactly 40*N cycles after the first low) and
    // that busy has dropped. Returns at the negedge of the done cycle.
    task automatic recv_frame(input string name);
        int         f;
        int         waited;
        logic [7:0] b;
        logic [7:0] e;
        f = 0;
        for (int j = 0; j < 4; j++) begin
            waited = 0;
            while (tx !== 1'b0 && waited < 3 * N) begin
                @(negedge clk);
                waited++;
            end
            if (tx !== 1'b0) begin
                check({name, "_start_timeout"}, 32'(tx), 32'd0);
                return;
            end
            if (j == 0) f = cycle;
            check({name, "_byte_slot"}, 32'(cycle - f), 32'(10 * N * j));
            repeat (N / 2) @(negedge clk);
            check({name, "_start_bit"}, 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (N) @(negedge clk);
                b[i] = tx;
            end
            repeat (N) @(negedge clk);
            check({name, "_stop_bit"}, 32'(tx), 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({name, "_byte"}, 32'(b), 32'(e));
        end
        waited = 0;
        while (done !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_frame_len"}, 32'(cycle - f), 32'(40 * N));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  rises0;
        bit  done_seen;
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        busy_rises  = 0;
        busy_prev   = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        q_a         = 4'd0;
        q_b         = 4'd0;

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum_out), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] normal frame 7+5");
        launch(4'd7, 4'd5, 1'b0);
        recv_frame("t1");
        repeat (5) @(negedge clk);

        $display("[TB] boundary 0+0 and 15+15");
        launch(4'd0, 4'd0, 1'b0);
        recv_frame("t2a");
        repeat (5) @(negedge clk);
        launch(4'd15, 4'd15, 1'b0);
        recv_frame("t2b");
        repeat (5) @(negedge clk);

        $display("[TB] start while busy, operands changed mid-frame");
        rises0 = busy_rises;
        launch(4'd4, 4'd9, 1'b0);
        fork
            recv_frame("t3");
            begin
                repeat (50) @(negedge clk);
                q_a   = 4'd3;
                q_b   = 4'd1;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        check("t3_frames", 32'(busy_rises - rises0), 32'd1);
        check("t3_idle_tx", 32'(tx), 32'd1);

        $display("[TB] start held high for 500 cycles");
        rises0 = busy_rises;
        launch(4'd2, 4'd6, 1'b1);
        fork
            recv_frame("t4");
            begin
                repeat (500) @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("t4_frames", 32'(busy_rises - rises0), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        $display("[TB] reset mid-frame");
        launch(4'd5, 4'd5, 1'b0);
        done_seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_sum", 32'(sum_out), 32'd0);
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("t5_no_done", 32'(done_seen), 32'd0);
        launch(4'd15, 4'd0, 1'b0);
        recv_frame("t5");
        repeat (5) @(negedge clk);

        $display("[TB] back-to-back frames");
        launch(4'd1, 4'd2, 1'b0);
        recv_frame("t6a");
        q_a   = 4'd9;
        q_b   = 4'd9;
        start = 1'b1;
        push_expected(4'd9, 4'd9);
        @(negedge clk);
        start = 1'b0;
        check("t6_tx_fall", 32'(tx), 32'd0);
        check("t6_sum", 32'(sum_out), 32'd18);
        recv_frame("t6b");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
